// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage. Registers the EX->MEM bus,
//            aligns/extends load data and selects the write-back value.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int EX_TO_MEM_WD = 81,
  parameter int MEM_TO_WB_WD = 70,
  parameter int STALL_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_id_fwd
);

  localparam int c_stall_mem = 3;
  localparam int c_stall_wb  = 4;

  logic [EX_TO_MEM_WD-1:0] r_bus;
  logic [31:0]             r_rdata_hold;
  logic                    r_hold_vld;

  logic        w_stall_mem;
  logic        w_bubble;
  logic        w_hold;
  logic [4:0]  w_mem_op;
  logic [31:0] w_pc;
  logic        w_sel_rf_res;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_ex_result;
  logic [31:0] w_rdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_rf_wdata;
  logic        w_unused;

  assign w_stall_mem = stall[c_stall_mem];
  assign w_bubble    = stall[c_stall_mem] & ~stall[c_stall_wb];
  assign w_hold      = stall[c_stall_mem] &  stall[c_stall_wb];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus <= '0;
    end else if (flush || w_bubble) begin
      r_bus <= '0;
    end else if (!w_stall_mem) begin
      r_bus <= ex_to_mem_bus;
    end
  end

  // SRAM output is only trustworthy in the first cycle of a hold; keep that copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata_hold <= 32'd0;
      r_hold_vld   <= 1'b0;
    end else if (flush || !w_hold) begin
      r_hold_vld   <= 1'b0;
    end else if (!r_hold_vld) begin
      r_rdata_hold <= data_sram_rdata;
      r_hold_vld   <= 1'b1;
    end
  end

  assign w_mem_op     = r_bus[80:76];
  assign w_pc         = r_bus[75:44];
  assign w_sel_rf_res = r_bus[38];
  assign w_rf_we      = r_bus[37];
  assign w_rf_waddr   = r_bus[36:32];
  assign w_ex_result  = r_bus[31:0];

  assign w_rdata = r_hold_vld ? r_rdata_hold : data_sram_rdata;

  always_comb begin
    w_byte = 8'd0;
    case (w_ex_result[1:0])
      2'd0:    w_byte = w_rdata[7:0];
      2'd1:    w_byte = w_rdata[15:8];
      2'd2:    w_byte = w_rdata[23:16];
      default: w_byte = w_rdata[31:24];
    endcase
  end

  assign w_half = w_ex_result[1] ? w_rdata[31:16] : w_rdata[15:0];

  // mem_op one-hot: {lb, lbu, lh, lhu, lw}; misaligned halfwords yield 0.
  always_comb begin
    w_load_data = 32'd0;
    if (w_mem_op[4]) begin
      w_load_data = {{24{w_byte[7]}}, w_byte};
    end else if (w_mem_op[3]) begin
      w_load_data = {24'd0, w_byte};
    end else if (w_mem_op[2]) begin
      w_load_data = w_ex_result[0] ? 32'd0 : {{16{w_half[15]}}, w_half};
    end else if (w_mem_op[1]) begin
      w_load_data = w_ex_result[0] ? 32'd0 : {16'd0, w_half};
    end else if (w_mem_op[0]) begin
      w_load_data = w_rdata;
    end
  end

  assign w_rf_wdata = w_sel_rf_res ? w_load_data : w_ex_result;

  assign mem_to_wb_bus = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
  assign mem_to_id_fwd = {w_rf_we, w_rf_waddr, w_rf_wdata};

  assign w_unused = ^{r_bus[43:39], stall[STALL_W-1:c_stall_wb+1], stall[c_stall_mem-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed self-checking bench for mem_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int c_ex_wd = 81;
  localparam int c_wb_wd = 70;
  localparam int c_st_w  = 6;

  localparam logic [4:0] c_op_lb  = 5'b10000;
  localparam logic [4:0] c_op_lbu = 5'b01000;
  localparam logic [4:0] c_op_lh  = 5'b00100;
  localparam logic [4:0] c_op_lhu = 5'b00010;
  localparam logic [4:0] c_op_lw  = 5'b00001;

  localparam logic [5:0] c_run    = 6'b000000;
  localparam logic [5:0] c_bubble = 6'b001000;
  localparam logic [5:0] c_hold   = 6'b011000;

  logic               clk;
  logic               rst;
  logic               flush;
  logic [c_st_w-1:0]  stall;
  logic [c_ex_wd-1:0] ex_to_mem_bus;
  logic [31:0]        data_sram_rdata;
  logic [c_wb_wd-1:0] mem_to_wb_bus;
  logic [37:0]        mem_to_id_fwd;

  int n_checks;
  int n_errors;

  mem_stage #(
    .EX_TO_MEM_WD(c_ex_wd),
    .MEM_TO_WB_WD(c_wb_wd),
    .STALL_W     (c_st_w)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .stall          (stall),
    .ex_to_mem_bus  (ex_to_mem_bus),
    .data_sram_rdata(data_sram_rdata),
    .mem_to_wb_bus  (mem_to_wb_bus),
    .mem_to_id_fwd  (mem_to_id_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [c_ex_wd-1:0] mk_bus(input logic [4:0] op, input logic [31:0] pc,
                                                input logic [3:0] wen, input logic sel,
                                                input logic we, input logic [4:0] waddr,
                                                input logic [31:0] res);
    return {op, pc, (op != 5'd0) || (wen != 4'd0), wen, sel, we, waddr, res};
  endfunction

  // Issue one instruction, advance one edge, present rdata, check both output buses.
  task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] pc,
                       input logic sel, input logic we, input logic [4:0] waddr,
                       input logic [31:0] res, input logic [31:0] rdata,
                       input logic [31:0] exp_wdata);
    stall         = c_run;
    flush         = 1'b0;
    ex_to_mem_bus = mk_bus(op, pc, 4'd0, sel, we, waddr, res);
    @(posedge clk);
    #1;
    data_sram_rdata = rdata;
    #1;
    check({tag, "_wb"},  128'(mem_to_wb_bus), 128'({pc, we, waddr, exp_wdata}));
    check({tag, "_fwd"}, 128'(mem_to_id_fwd), 128'({we, waddr, exp_wdata}));
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b0;
    flush           = 1'b0;
    stall           = c_run;
    data_sram_rdata = 32'd0;
    ex_to_mem_bus   = mk_bus(5'd0, 32'h0000_0100, 4'd0, 1'b0, 1'b1, 5'd9, 32'h5555_AAAA);

    // Asynchronous reset between edges
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_wb",   128'(mem_to_wb_bus), 128'd0);
    check("rst_fwd",  128'(mem_to_id_fwd), 128'd0);
    check("rst_hold", 128'(dut.r_hold_vld), 128'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Byte loads
    issue("lb",  c_op_lb,  32'h0000_0400, 1'b1, 1'b1, 5'd5, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80);
    issue("lbu", c_op_lbu, 32'h0000_0404, 1'b1, 1'b1, 5'd5, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080);
    issue("lb0", c_op_lb,  32'h0000_0408, 1'b1, 1'b1, 5'd6, 32'h0000_1001, 32'h80FF_1234, 32'h0000_0012);

    // Halfword loads, including misaligned
    issue("lh_hi",  c_op_lh,  32'h0000_0410, 1'b1, 1'b1, 5'd8, 32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001);
    issue("lhu_lo", c_op_lhu, 32'h0000_0414, 1'b1, 1'b1, 5'd8, 32'h0000_2000, 32'h8001_7FFF, 32'h0000_7FFF);
    issue("lh_mis", c_op_lh,  32'h0000_0418, 1'b1, 1'b1, 5'd8, 32'h0000_2001, 32'h8001_7FFF, 32'h0000_0000);
    issue("nop_ld", 5'd0,     32'h0000_041C, 1'b1, 1'b1, 5'd2, 32'h0000_2000, 32'h8001_7FFF, 32'h0000_0000);

    // lw followed by a 3-cycle full stall while the SRAM output changes
    issue("lw", c_op_lw, 32'h0000_0500, 1'b1, 1'b1, 5'd7, 32'h0000_3000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    stall         = c_hold;
    ex_to_mem_bus = mk_bus(5'd0, 32'h0000_0504, 4'd0, 1'b0, 1'b1, 5'd1, 32'h0BAD_0BAD);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      data_sram_rdata = 32'h1111_1111;
      #1;
      check("lw_held", 128'(mem_to_wb_bus), 128'({32'h0000_0500, 1'b1, 5'd7, 32'hDEAD_BEEF}));
      check("hold_vld_set", 128'(dut.r_hold_vld), 128'd1);
    end
    issue("lw_next", c_op_lw, 32'h0000_0508, 1'b1, 1'b1, 5'd9, 32'h0000_3004, 32'h1111_1111, 32'h1111_1111);
    check("hold_vld_clr", 128'(dut.r_hold_vld), 128'd0);

    // Reset asserted in the middle of a held load
    issue("lw_rst", c_op_lw, 32'h0000_0600, 1'b1, 1'b1, 5'd4, 32'h0000_3008, 32'hCAFE_F00D, 32'hCAFE_F00D);
    stall = c_hold;
    @(posedge clk);
    #1;
    data_sram_rdata = 32'h0000_0000;
    #1;
    check("lw_rst_held", 128'(mem_to_wb_bus), 128'({32'h0000_0600, 1'b1, 5'd4, 32'hCAFE_F00D}));
    rst = 1'b1;
    #1;
    check("midrst_wb",   128'(mem_to_wb_bus), 128'd0);
    check("midrst_hold", 128'(dut.r_hold_vld), 128'd0);
    #1;
    rst   = 1'b0;
    stall = c_run;

    // ALU pass-through, then bubble
    issue("alu", 5'd0, 32'h0000_0700, 1'b0, 1'b1, 5'd31, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678);
    stall         = c_bubble;
    ex_to_mem_bus = mk_bus(5'd0, 32'h0000_0704, 4'd0, 1'b0, 1'b1, 5'd3, 32'h0000_0042);
    @(posedge clk);
    #2;
    check("bubble_wb",  128'(mem_to_wb_bus), 128'd0);
    check("bubble_fwd", 128'(mem_to_id_fwd), 128'd0);

    // Flush beats a valid input
    issue("alu2", 5'd0, 32'h0000_0708, 1'b0, 1'b1, 5'd3, 32'h0000_0042, 32'h0, 32'h0000_0042);
    stall         = c_run;
    flush         = 1'b1;
    ex_to_mem_bus = mk_bus(5'd0, 32'h0000_070C, 4'd0, 1'b0, 1'b1, 5'd3, 32'h0000_0099);
    @(posedge clk);
    #2;
    check("flush_wb", 128'(mem_to_wb_bus), 128'd0);
    flush = 1'b0;

    // Flush with both stalls asserted also clears
    issue("alu3", 5'd0, 32'h0000_0710, 1'b0, 1'b1, 5'd10, 32'h0000_0077, 32'h0, 32'h0000_0077);
    stall = c_hold;
    flush = 1'b1;
    @(posedge clk);
    #2;
    check("flush_stall_wb", 128'(mem_to_wb_bus), 128'd0);
    flush = 1'b0;
    stall = c_run;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
